// File: rtl/rca_multiword_seq.sv
// rca_multiword_seq
//   Adds two W-bit operands (W = 4*NSLICE) plus a carry-in by reusing one 4-bit
//   ripple-carry slice, one nibble per clock, least significant nibble first.
//   The slice carry-out is registered between nibbles. The result register is
//   updated all at once on the last nibble, so partial sums never show on sum.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, only looked at in IDLE
//   a, b   in   W-bit operands, captured when start is accepted
//   cin    in   carry into nibble 0, captured when start is accepted
//   busy   out  high in RUN and DONE
//   done   out  one-cycle pulse when sum/cout have just been updated
//   sum    out  W-bit result, held until the next completion
//   cout   out  carry out of the top nibble, held with sum
//
// State  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start; sum/cout hold the last result
// RUN    | one nibble per cycle, idx selects the nibble
// DONE   | result valid, done pulses for this single cycle

module rca_multiword_seq #(
  parameter int NSLICE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*NSLICE-1:0]   a,
  input  logic [4*NSLICE-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*NSLICE-1:0]   sum,
  output logic                  cout
);

  localparam int W     = 4 * NSLICE;
  localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     op_a_q, op_a_d;
  logic [W-1:0]     op_b_q, op_b_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     sum_q, sum_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic [3:0]       a_nib, b_nib;
  logic [4:0]       slice_res;
  logic [W-1:0]     acc_merged;

  // The shared 4-bit slice: nibble select, add, and write-back position.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib = op_a_q[4*i +: 4];
        b_nib = op_b_q[4*i +: 4];
      end
    end
    slice_res = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
    acc_merged = acc_q;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == IDX_W'(i)) begin
        acc_merged[4*i +: 4] = slice_res[3:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_a_d  = a;
          op_b_d  = b;
          carry_d = cin;
          idx_d   = '0;
          acc_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d   = acc_merged;
        carry_d = slice_res[4];
        if (idx_q == LAST_IDX) begin
          // Publish the whole word at once, final nibble included.
          sum_d   = acc_merged;
          cout_d  = slice_res[4];
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_rca_multiword_seq.sv
// Bench for rca_multiword_seq: three instances (NSLICE = 1, 4, 8) share clock and
// reset. A cycle-level reference model predicts busy/done/sum/cout for each from
// the externally visible rules (accept when idle, NSLICE+1 busy cycles, result
// a+b+cin appears with the done pulse).

module tb_rca_multiword_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic        start_drv [3];
  logic [31:0] a_drv     [3];
  logic [31:0] b_drv     [3];
  logic        cin_drv   [3];

  logic        act_busy  [3];
  logic        act_done  [3];
  logic        act_cout  [3];
  logic [31:0] act_sum   [3];

  int          rem       [3];
  logic [63:0] pend      [3];
  logic [31:0] exp_sum   [3];
  logic        exp_cout  [3];
  int          ops       [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic int n_of(int g);
    return (g == 0) ? 1 : ((g == 1) ? 4 : 8);
  endfunction

  function automatic logic [63:0] mask_of(int g);
    return (64'd1 << (4 * n_of(g))) - 64'd1;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int N = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
    localparam int W = 4 * N;
    logic         busy_w, done_w, cout_w;
    logic [W-1:0] sum_w;
    rca_multiword_seq #(.NSLICE(N)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start_drv[g]),
      .a     (a_drv[g][W-1:0]),
      .b     (b_drv[g][W-1:0]),
      .cin   (cin_drv[g]),
      .busy  (busy_w),
      .done  (done_w),
      .sum   (sum_w),
      .cout  (cout_w)
    );
    assign act_busy[g] = busy_w;
    assign act_done[g] = done_w;
    assign act_cout[g] = cout_w;
    assign act_sum[g]  = 32'(sum_w);
  end

  // Reference model: rem counts remaining busy cycles; rem==1 is the done cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < 3; g++) begin
        rem[g]      = 0;
        pend[g]     = '0;
        exp_sum[g]  = '0;
        exp_cout[g] = 1'b0;
      end
    end else begin
      for (int g = 0; g < 3; g++) begin
        if (rem[g] == 0) begin
          if (start_drv[g]) begin
            rem[g]  = n_of(g) + 1;
            pend[g] = (64'(a_drv[g]) & mask_of(g)) + (64'(b_drv[g]) & mask_of(g))
                      + 64'(cin_drv[g]);
            ops[g]  = ops[g] + 1;
          end
        end else begin
          rem[g] = rem[g] - 1;
          if (rem[g] == 1) begin
            exp_sum[g]  = 32'(pend[g] & mask_of(g));
            exp_cout[g] = pend[g][4 * n_of(g)];
          end
        end
      end
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("busy[%0d]", g), 64'(act_busy[g]), 64'(rem[g] > 0));
      chk($sformatf("done[%0d]", g), 64'(act_done[g]), 64'(rem[g] == 1));
      chk($sformatf("sum[%0d]", g),  64'(act_sum[g]),  64'(exp_sum[g]));
      chk($sformatf("cout[%0d]", g), 64'(act_cout[g]), 64'(exp_cout[g]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int g, logic s, logic [31:0] av, logic [31:0] bv, logic c);
    start_drv[g] = s;
    a_drv[g]     = av;
    b_drv[g]     = bv;
    cin_drv[g]   = c;
  endtask

  task automatic wait_done(int g, int max, output int cyc);
    cyc = -1;
    for (int k = 1; k <= max; k++) begin
      tick();
      if (act_done[g]) begin
        cyc = k;
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    int cnt;
    int last;
    int base [3];
    bit all_done;

    for (int g = 0; g < 3; g++) begin
      drive(g, 1'b0, 32'd0, 32'd0, 1'b0);
      ops[g] = 0;
    end
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(act_busy[1]), 64'd0);
    chk("reset_done", 64'(act_done[1]), 64'd0);
    chk("reset_sum",  64'(act_sum[1]),  64'd0);
    chk("reset_cout", 64'(act_cout[1]), 64'd0);
    rst_n = 1'b1;
    tick();

    // FFFF + 0001: carry ripples through every nibble.
    drive(1, 1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0);
    tick();
    start_drv[1] = 1'b0;
    wait_done(1, 12, cyc);
    chk("t1_latency", 64'(cyc), 64'd4);
    chk("t1_sum", 64'(act_sum[1]), 64'h0000);
    chk("t1_cout", 64'(act_cout[1]), 64'd1);
    chk("t1_model_sum", 64'(exp_sum[1]), 64'h0000);
    tick();

    // 1234 + 4321 + 1, and count busy cycles.
    drive(1, 1'b1, 32'h0000_1234, 32'h0000_4321, 1'b1);
    tick();
    start_drv[1] = 1'b0;
    cnt = act_busy[1] ? 1 : 0;
    repeat (7) begin
      tick();
      if (act_busy[1]) cnt++;
    end
    chk("t2_busy_cycles", 64'(cnt), 64'd5);
    chk("t2_sum", 64'(act_sum[1]), 64'h5556);
    chk("t2_cout", 64'(act_cout[1]), 64'd0);
    chk("t2_model_sum", 64'(exp_sum[1]), 64'h5556);

    // Result holds while idle.
    cnt = 0;
    repeat (10) begin
      tick();
      if (act_done[1]) cnt++;
    end
    chk("t5_sum_hold", 64'(act_sum[1]), 64'h5556);
    chk("t5_no_done", 64'(cnt), 64'd0);

    // start held high; operands scrambled whenever the op is in flight.
    drive(1, 1'b1, 32'h0000_8000, 32'h0000_8000, 1'b0);
    cnt  = 0;
    last = -1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (act_done[1]) begin
        cnt++;
        chk("t3_sum", 64'(act_sum[1]), 64'h0000);
        chk("t3_cout", 64'(act_cout[1]), 64'd1);
        if (last >= 0) chk("t3_spacing", 64'(k - last), 64'd6);
        last = k;
      end
      if (rem[1] == 0) begin
        a_drv[1] = 32'h0000_8000; b_drv[1] = 32'h0000_8000; cin_drv[1] = 1'b0;
      end else begin
        a_drv[1] = $urandom; b_drv[1] = $urandom; cin_drv[1] = 1'($urandom);
      end
    end
    start_drv[1] = 1'b0;
    chk("t3_done_count", 64'(cnt), 64'd5);
    repeat (8) tick();

    // Reset in the middle of an operation (idx == 2).
    drive(1, 1'b1, 32'h0000_00FF, 32'h0000_0F01, 1'b0);
    tick();
    start_drv[1] = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t4_busy", 64'(act_busy[1]), 64'd0);
    chk("t4_done", 64'(act_done[1]), 64'd0);
    chk("t4_sum",  64'(act_sum[1]),  64'd0);
    chk("t4_cout", 64'(act_cout[1]), 64'd0);
    #3 rst_n = 1'b1;
    tick();
    cnt = 0;
    repeat (8) begin
      tick();
      if (act_done[1]) cnt++;
    end
    chk("t4_no_done", 64'(cnt), 64'd0);
    drive(1, 1'b1, 32'h0000_1234, 32'h0000_4321, 1'b1);
    tick();
    start_drv[1] = 1'b0;
    wait_done(1, 12, cyc);
    chk("t4_latency", 64'(cyc), 64'd4);
    chk("t4_after_sum", 64'(act_sum[1]), 64'h5556);
    tick();

    // Single-slice instance.
    drive(0, 1'b1, 32'h0000_000F, 32'h0000_000F, 1'b1);
    tick();
    start_drv[0] = 1'b0;
    wait_done(0, 6, cyc);
    chk("t6_latency", 64'(cyc), 64'd1);
    chk("t6_sum", 64'(act_sum[0]), 64'hF);
    chk("t6_cout", 64'(act_cout[0]), 64'd1);
    tick();

    // Random sweep, all three instances in parallel, 1000 ops each.
    for (int g = 0; g < 3; g++) base[g] = ops[g];
    all_done = 1'b0;
    for (int c = 0; c < 40000 && !all_done; c++) begin
      all_done = 1'b1;
      for (int g = 0; g < 3; g++) begin
        if (ops[g] - base[g] < 1000) begin
          all_done = 1'b0;
          drive(g, 1'(($urandom % 4) != 0), $urandom, $urandom, 1'($urandom));
        end else begin
          drive(g, 1'b0, $urandom, $urandom, 1'($urandom));
        end
      end
      tick();
    end
    chk("sweep_complete", 64'(all_done), 64'd1);
    for (int g = 0; g < 3; g++) start_drv[g] = 1'b0;
    repeat (12) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
